icache_refill_ctrl: RTL and testbench

- Sequences instruction-cache line refills on a fetch miss.
- Latches the missing line address, issues a read request to the memory interface, and counts returned words into the cache data array.
- Drives InstrMissF and InstrCacheRepActive to the hazard unit, and pulses completion so the fetch stage re-looks-up and hits.
- Sits between the fetch-stage cache lookup, the backing memory port and the pipeline hazard logic.

---
 rtl/icache_refill_ctrl_if.sv | 46 ++++
 rtl/icache_refill_ctrl.sv | 120 ++++++++++++
 tb/tb_icache_refill_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_if.sv
// Signal bundle between the I-cache refill controller and its neighbours:
// fetch lookup, backing memory port, cache data array and hazard unit.
interface icache_refill_ctrl_if #(
    parameter int WIDX_W = 2,
    parameter int CNT_W  = 16
);
    // Fetch stage / execute redirect
    logic              MissF;
    logic [31:0]       PCF;
    logic              Redirect;

    // Backing memory port
    logic              MemReq;
    logic [31:0]       MemAddr;
    logic              MemReady;
    logic              MemRValid;
    logic [31:0]       MemRData;

    // Cache data array write port
    logic              RepWE;
    logic [WIDX_W-1:0] RepWordIdx;
    logic [31:0]       RepData;
    logic [31:0]       RepLineAddr;
    logic              RepDone;

    // Hazard unit and performance counter
    logic              InstrMissF;
    logic              InstrCacheRepActive;
    logic [CNT_W-1:0]  MissCount;

    modport master (
        input  MissF, PCF, Redirect,
        input  MemReady, MemRValid, MemRData,
        output MemReq, MemAddr,
        output RepWE, RepWordIdx, RepData, RepLineAddr, RepDone,
        output InstrMissF, InstrCacheRepActive, MissCount
    );

    modport slave (
        output MissF, PCF, Redirect,
        output MemReady, MemRValid, MemRData,
        input  MemReq, MemAddr,
        input  RepWE, RepWordIdx, RepData, RepLineAddr, RepDone,
        input  InstrMissF, InstrCacheRepActive, MissCount
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill sequencer: latches the missing line, requests it
// from memory, streams returned words into the data array and signals completion.
module icache_refill_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int WIDX_W         = 2,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    icache_refill_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [31:0]       OFF_MASK  = 32'(WORDS_PER_LINE * 4 - 1);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_LINE - 1);

    state_e            state_q, state_d;
    logic [WIDX_W-1:0] cnt_q, cnt_d;
    logic [31:0]       line_q, line_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic mem_req;
    logic miss_f;
    logic rep_we;
    logic rep_done;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its peers, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            line_q     <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        miss_cnt_d = miss_cnt_q;
        mem_req    = 1'b0;
        miss_f     = 1'b0;
        rep_we     = 1'b0;
        rep_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Gated by reset so the stall request is quiet while held in reset.
                miss_f = bus.MissF & reset;
                if (bus.MissF && !bus.Redirect) begin
                    line_d  = bus.PCF & ~OFF_MASK;
                    state_d = REQ;
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end

            REQ: begin
                miss_f  = 1'b1;
                // A redirect withdraws the request in the same cycle, so a
                // concurrent MemReady never completes a handshake.
                mem_req = !bus.Redirect;
                if (bus.Redirect) begin
                    state_d = IDLE;
                end else if (bus.MemReady) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end

            FILL: begin
                miss_f = 1'b1;
                if (bus.MemRValid) begin
                    rep_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                rep_done = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.MemReq              = mem_req;
    assign bus.MemAddr             = line_q;
    assign bus.RepWE               = rep_we;
    assign bus.RepWordIdx          = cnt_q;
    assign bus.RepData             = rep_we ? bus.MemRData : 32'd0;
    assign bus.RepLineAddr         = line_q;
    assign bus.RepDone             = rep_done;
    assign bus.InstrMissF          = miss_f;
    assign bus.InstrCacheRepActive = (state_q == FILL);
    assign bus.MissCount           = miss_cnt_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a scoreboard of expected array writes.
module tb_icache_refill_ctrl;

    localparam int WPL    = 4;
    localparam int WIDX_W = 2;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [WIDX_W-1:0] idx;
        logic [31:0]       data;
    } wr_t;

    logic clk;
    logic reset;

    icache_refill_ctrl_if #(.WIDX_W(WIDX_W), .CNT_W(CNT_W)) bus ();

    icache_refill_ctrl #(
        .WORDS_PER_LINE(WPL),
        .WIDX_W        (WIDX_W),
        .CNT_W         (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int wr_cnt      = 0;
    int done_cnt    = 0;
    int wr_base;
    logic [WIDX_W-1:0] exp_idx;
    wr_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic missf, input logic [31:0] pcf, input logic redirect,
                          input logic ready, input logic rvalid, input logic [31:0] rdata);
        bus.MissF     = missf;
        bus.PCF       = pcf;
        bus.Redirect  = redirect;
        bus.MemReady  = ready;
        bus.MemRValid = rvalid;
        bus.MemRData  = rdata;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_memreq"},  32'(bus.MemReq), 0);
        check({tag, "_memaddr"}, bus.MemAddr, 0);
        check({tag, "_repwe"},   32'(bus.RepWE), 0);
        check({tag, "_widx"},    32'(bus.RepWordIdx), 0);
        check({tag, "_repdata"}, bus.RepData, 0);
        check({tag, "_lineaddr"}, bus.RepLineAddr, 0);
        check({tag, "_repdone"}, 32'(bus.RepDone), 0);
        check({tag, "_missf"},   32'(bus.InstrMissF), 0);
        check({tag, "_active"},  32'(bus.InstrCacheRepActive), 0);
        check({tag, "_misscnt"}, 32'(bus.MissCount), 0);
    endtask

    // One returned word in FILL: expectation goes to the scoreboard now.
    task automatic fill_word(input string tag, input logic [31:0] data, input logic redirect);
        sb_q.push_back('{idx: exp_idx, data: data});
        exp_idx = exp_idx + 1'b1;
        set_in(1'b0, 32'h0, redirect, 1'b0, 1'b1, data);
        check({tag, "_we"},     32'(bus.RepWE), 1);
        check({tag, "_active"}, 32'(bus.InstrCacheRepActive), 1);
        check({tag, "_missf"},  32'(bus.InstrMissF), 1);
        tick();
    endtask

    // IDLE miss followed by an immediately accepted request; leaves DUT in FILL.
    task automatic start_line(input string tag, input logic [31:0] pcf, input logic [31:0] line);
        set_in(1'b1, pcf, 1'b0, 1'b0, 1'b0, 32'h0);
        check({tag, "_missf_comb"}, 32'(bus.InstrMissF), 1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        check({tag, "_req"},  32'(bus.MemReq), 1);
        check({tag, "_addr"}, bus.MemAddr, line);
        tick();
        exp_idx = '0;
        wr_base = wr_cnt;
    endtask

    // Monitor: every array write is compared against the scoreboard head.
    always @(negedge clk) begin
        if (reset && bus.RepDone) done_cnt++;
        if (reset && bus.RepWE) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_repwe", 32'(bus.RepWE), 0);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_idx",  32'(bus.RepWordIdx), 32'(e.idx));
                check("wr_data", bus.RepData, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with live inputs: outputs must all read zero.
        reset = 1'b0;
        exp_idx = '0;
        wr_base = 0;
        set_in(1'b1, 32'h0000_1234, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        check_all_zero("por");
        tick();
        tick();
        reset = 1'b1;

        // Basic miss with delayed MemReady and a back-to-back burst.
        set_in(1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0);
        check("basic_missf_comb", 32'(bus.InstrMissF), 1);
        check("basic_idle_noreq", 32'(bus.MemReq), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
            check("basic_req",   32'(bus.MemReq), 1);
            check("basic_addr",  bus.MemAddr, 32'h0000_1230);
            check("basic_stall", 32'(bus.InstrMissF), 1);
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("basic_req_acc", 32'(bus.MemReq), 1);
        check("basic_cnt",     32'(bus.MissCount), 1);
        tick();
        exp_idx = '0;
        wr_base = wr_cnt;
        for (int i = 0; i < 4; i++) fill_word("basic_fill", 32'hA0 + 32'(i), 1'b0);
        set_in(1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0);
        check("basic_done",        32'(bus.RepDone), 1);
        check("basic_done_missf",  32'(bus.InstrMissF), 0);
        check("basic_done_active", 32'(bus.InstrCacheRepActive), 0);
        check("basic_lineaddr",    bus.RepLineAddr, 32'h0000_1230);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("basic_after_done", 32'(bus.RepDone), 0);
        check("basic_after_req",  32'(bus.MemReq), 0);
        check("basic_writes",     32'(wr_cnt - wr_base), 4);
        check("basic_done_cnt",   32'(done_cnt), 1);
        check("basic_misscnt",    32'(bus.MissCount), 1);

        // Bubbled return: valid pattern 1,0,0,1,1,0,1.
        start_line("bub", 32'h0000_2008, 32'h0000_2000);
        begin
            logic [6:0] pat;
            pat = 7'b1011001;  // bit 0 first
            for (int i = 0; i < 7; i++) begin
                if (pat[i]) begin
                    fill_word("bub_fill", 32'hB0 + 32'(i), 1'b0);
                end else begin
                    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
                    check("bub_bubble_we", 32'(bus.RepWE), 0);
                    check("bub_bubble_active", 32'(bus.InstrCacheRepActive), 1);
                    tick();
                end
            end
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("bub_done", 32'(bus.RepDone), 1);
        tick();
        check("bub_writes",  32'(wr_cnt - wr_base), 4);
        check("bub_misscnt", 32'(bus.MissCount), 2);

        // Redirect in REQ coinciding with MemReady.
        wr_base = wr_cnt;
        set_in(1'b1, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        set_in(1'b1, 32'h0000_3004, 1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_req_gated", 32'(bus.MemReq), 0);
        check("redir_req_missf", 32'(bus.InstrMissF), 1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("redir_idle_req",   32'(bus.MemReq), 0);
        check("redir_idle_missf", 32'(bus.InstrMissF), 0);
        tick();
        set_in(1'b1, 32'h0000_3100, 1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_follow_missf", 32'(bus.InstrMissF), 1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0BAD);
        check("redir_stay_idle",  32'(bus.MemReq), 0);
        check("spurious_rv_we",   32'(bus.RepWE), 0);
        check("spurious_rv_data", bus.RepData, 0);
        tick();
        check("redir_no_writes", 32'(wr_cnt - wr_base), 0);
        check("redir_no_done",   32'(done_cnt), 2);
        check("redir_misscnt",   32'(bus.MissCount), 3);

        // Redirect during FILL is ignored; the line completes.
        start_line("rfill", 32'h0000_401C, 32'h0000_4010);
        fill_word("rfill_w0", 32'hC0, 1'b0);
        fill_word("rfill_w1", 32'hC1, 1'b1);
        fill_word("rfill_w2", 32'hC2, 1'b1);
        fill_word("rfill_w3", 32'hC3, 1'b0);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("rfill_done",    32'(bus.RepDone), 1);
        check("rfill_missf",   32'(bus.InstrMissF), 0);
        tick();
        check("rfill_writes",  32'(wr_cnt - wr_base), 4);
        check("rfill_misscnt", 32'(bus.MissCount), 4);

        // Reset after two words of a fill abandons the line.
        start_line("rmid", 32'h0000_5000, 32'h0000_5000);
        fill_word("rmid_w0", 32'hD0, 1'b0);
        fill_word("rmid_w1", 32'hD1, 1'b0);
        reset = 1'b0;
        set_in(1'b1, 32'h0000_5000, 1'b0, 1'b1, 1'b1, 32'hD2);
        check_all_zero("rmid");
        tick();
        reset = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rmid_idle_req",    32'(bus.MemReq), 0);
        check("rmid_idle_active", 32'(bus.InstrCacheRepActive), 0);
        check("rmid_misscnt",     32'(bus.MissCount), 0);
        tick();
        check("rmid_no_done", 32'(done_cnt), 3);

        // Saturation of the 4-bit miss counter over 20 aborted misses.
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 32'h0000_6000 + 32'(i * 16), 1'b0, 1'b0, 1'b0, 32'h0);
            tick();
            set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
            tick();
            if (i == 13) check("sat_cnt_14", 32'(bus.MissCount), 14);
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0BAD);
        check("sat_cnt_hold",  32'(bus.MissCount), 32'h0000_000F);
        check("sat_spur_we",   32'(bus.RepWE), 0);
        tick();

        check("sb_drained",  32'(sb_q.size()), 0);
        check("total_done",  32'(done_cnt), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
